// File: rtl/linebuffer_ctrl_pkg.sv
// linebuffer_pkg: shared types and width helpers for the line-buffer
// stencil controllers.
//   lb_state_e - controller state (IDLE, RUN)
//   lb_cnt_w   - bit width of a counter for range 0..n-1 (minimum 1)
package linebuffer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } lb_state_e;

    function automatic int lb_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/linebuffer_ctrl_if.sv
// linebuffer_ctrl_if: pixel-in and window-out handshakes of linebuffer_ctrl.
//   in_valid/in_sof/in_ready     - raster pixel stream from the source
//   win_valid/win_sof/win_eol    - completed-window flags to the kernel
//   win_ready                    - kernel consumes the window
// slave  = controller side, master = source/kernel side.
interface linebuffer_ctrl_if;

    logic in_valid;
    logic in_sof;
    logic in_ready;
    logic win_valid;
    logic win_ready;
    logic win_sof;
    logic win_eol;

    modport slave (
        input  in_valid, in_sof, win_ready,
        output in_ready, win_valid, win_sof, win_eol
    );

    modport master (
        output in_valid, in_sof, win_ready,
        input  in_ready, win_valid, win_sof, win_eol
    );

endinterface

// File: rtl/linebuffer_ctrl_raster_counter.sv
// raster_counter: column/row position of the most recently counted pixel.
//   clk, rst - clock, async active-high reset
//   clr      - the pixel being counted is the first of a frame: load (0,0)
//   inc      - advance one pixel in raster order (wraps explicitly)
//   col, row - position of the most recently counted pixel
//   last     - the next inc lands on (WIDTH-1, HEIGHT-1), the final pixel
module raster_counter
    import linebuffer_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int HEIGHT = 8,
    localparam int CW     = lb_cnt_w(WIDTH),
    localparam int RW     = lb_cnt_w(HEIGHT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          last
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (clr) begin
            col <= '0;
            row <= '0;
        end else if (inc) begin
            if (col == CW'(WIDTH - 1)) begin
                col <= '0;
                row <= (row == RW'(HEIGHT - 1)) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Looks one pixel ahead so the caller can act on the accept of the
    // final pixel itself rather than a cycle late.
    assign last = (col == CW'(WIDTH - 2)) && (row == RW'(HEIGHT - 1));

endmodule

// File: rtl/linebuffer_ctrl.sv
// linebuffer_ctrl: stream controller for the line-buffer stencil path.
//   clk, rst   - clock, async active-high reset
//   bus        - pixel-in / window-out handshakes (slave modport)
//   shift_en   - advance line buffers and window registers (combinational)
//   col, row   - position of the most recently shifted pixel
//   frame_done - pulse the cycle after the last pixel of a frame shifts
//   sync_err   - pulse after a framing violation (stray pixel or in_sof)
module linebuffer_ctrl
    import linebuffer_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int HEIGHT = 8,
    parameter  int KERNEL = 3,
    localparam int CW     = lb_cnt_w(WIDTH),
    localparam int RW     = lb_cnt_w(HEIGHT)
) (
    input  logic              clk,
    input  logic              rst,
    linebuffer_ctrl_if.slave  bus,
    output logic              shift_en,
    output logic [CW-1:0]     col,
    output logic [RW-1:0]     row,
    output logic              frame_done,
    output logic              sync_err
);

    lb_state_e     state;
    logic          win_valid_q, win_sof_q, win_eol_q;
    logic          frame_done_q, sync_err_q;
    logic          in_ready, accept, sof_acc, inc, cnt_last;
    logic          col_wrap, completing;
    logic [CW-1:0] nxt_col;
    logic [RW-1:0] nxt_row;

    raster_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (sof_acc),
        .inc  (inc),
        .col  (col),
        .row  (row),
        .last (cnt_last)
    );

    always_comb begin
        // Holding in_ready low while a window waits keeps the taps frozen.
        in_ready = (state == IDLE) || !win_valid_q || bus.win_ready;
        accept   = bus.in_valid && in_ready;
        sof_acc  = accept && bus.in_sof;
        shift_en = accept && ((state == RUN) || bus.in_sof);
        inc      = shift_en && !bus.in_sof;
        // Position of the pixel being shifted now (non-SOF case). An SOF
        // pixel lands at (0,0) and can never complete a window.
        col_wrap   = (col == CW'(WIDTH - 1));
        nxt_col    = col_wrap ? '0 : col + CW'(1);
        nxt_row    = col_wrap ? row + RW'(1) : row;
        completing = inc && (nxt_col >= CW'(KERNEL - 1)) &&
                     (nxt_row >= RW'(KERNEL - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            win_valid_q  <= 1'b0;
            win_sof_q    <= 1'b0;
            win_eol_q    <= 1'b0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            frame_done_q <= inc && cnt_last;
            sync_err_q   <= accept && (((state == IDLE) && !bus.in_sof) ||
                                       ((state == RUN)  &&  bus.in_sof));
            case (state)
                IDLE:    if (sof_acc) state <= RUN;
                RUN:     if (inc && cnt_last) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (completing) begin
                win_valid_q <= 1'b1;
                win_sof_q   <= (nxt_col == CW'(KERNEL - 1)) &&
                               (nxt_row == RW'(KERNEL - 1));
                win_eol_q   <= col_wrap ? 1'b0 : (nxt_col == CW'(WIDTH - 1));
            end else if (bus.win_ready) begin
                win_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.win_valid = win_valid_q;
    assign bus.win_sof   = win_sof_q;
    assign bus.win_eol   = win_eol_q;
    assign frame_done    = frame_done_q;
    assign sync_err      = sync_err_q;

endmodule

// File: tb/tb_linebuffer_ctrl.sv
module tb_linebuffer_ctrl;

    localparam int W = 8;
    localparam int H = 6;
    localparam int K = 3;

    logic       clk;
    logic       rst;
    logic       shift_en, frame_done, sync_err;
    logic [2:0] col;
    logic [2:0] row;

    linebuffer_ctrl_if bus();

    linebuffer_ctrl #(.WIDTH(W), .HEIGHT(H), .KERNEL(K)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .shift_en   (shift_en),
        .col        (col),
        .row        (row),
        .frame_done (frame_done),
        .sync_err   (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // per-scenario activity counters
    int n_acc, n_shift, n_win, n_eol, n_wsof, n_fd, n_fd_shift, n_serr;
    int n_stall, n_stall_shift, first_win_acc, fd_acc;
    bit last_acc;

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        n_acc = 0; n_shift = 0; n_win = 0; n_eol = 0; n_wsof = 0;
        n_fd = 0; n_fd_shift = 0; n_serr = 0; n_stall = 0;
        n_stall_shift = 0; first_win_acc = -1; fd_acc = -1;
    endtask

    // One clock: sample at negedge (inputs settled), return 1 after posedge.
    task automatic tick();
        bit acc;
        @(negedge clk);
        acc = bus.in_valid && bus.in_ready;
        if (bus.win_valid && bus.win_ready) begin
            n_win++;
            if (bus.win_eol) n_eol++;
            if (bus.win_sof) begin
                n_wsof++;
                if (first_win_acc < 0) first_win_acc = n_acc;
            end
        end
        if (frame_done) begin
            n_fd++;
            fd_acc = n_acc;
            if (shift_en) n_fd_shift++;
        end
        if (sync_err) n_serr++;
        if (shift_en) n_shift++;
        if (bus.win_valid && !bus.win_ready) begin
            n_stall++;
            if (shift_en) n_stall_shift++;
        end
        if (acc) n_acc++;
        last_acc = acc;
        @(posedge clk);
        #1;
    endtask

    // Push n pixels (first carries in_sof if sof_first). mode 1 toggles
    // win_ready 1-0-1 per cycle.
    task automatic send_pixels(input int n, input bit sof_first, input int mode);
        int i = 0;
        int cyc = 0;
        while (i < n && cyc < 2000) begin
            bus.in_valid  = 1'b1;
            bus.in_sof    = (i == 0) && sof_first;
            bus.win_ready = (mode == 1) ? ((cyc % 3) != 1) : 1'b1;
            tick();
            cyc++;
            if (last_acc) i++;
        end
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        check("send_complete", i, n);
    endtask

    task automatic drain(input int n);
        bus.in_valid  = 1'b0;
        bus.in_sof    = 1'b0;
        bus.win_ready = 1'b1;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_sof    = 1'b0;
        bus.win_ready = 1'b0;
        clear_counts();
        #12;
        // reset values
        check("rst_in_ready",   int'(bus.in_ready), 1);
        check("rst_shift_en",   int'(shift_en), 0);
        check("rst_win_valid",  int'(bus.win_valid), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_sync_err",   int'(sync_err), 0);
        check("rst_col_row",    int'({col, row}), 0);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: full frame, win_ready held high
        clear_counts();
        send_pixels(48, 1'b1, 0);
        drain(3);
        check("s1_first_win_acc", first_win_acc, 19);
        check("s1_windows",       n_win, 24);
        check("s1_eol",           n_eol, 4);
        check("s1_win_sof",       n_wsof, 1);
        check("s1_frame_done",    n_fd, 1);
        check("s1_fd_after_acc",  fd_acc, 48);
        check("s1_shifts",        n_shift, 48);
        check("s1_sync_err",      n_serr, 0);
        check("s1_end_col_row",   int'({col, row}), {3'd7, 3'd5});

        // 2: same frame, win_ready toggling 1-0-1
        clear_counts();
        send_pixels(48, 1'b1, 1);
        drain(3);
        check("s2_windows",     n_win, 24);
        check("s2_eol",         n_eol, 4);
        check("s2_stalled",     int'(n_stall > 0), 1);
        check("s2_stall_shift", n_stall_shift, 0);
        check("s2_frame_done",  n_fd, 1);

        // 3: stray pixels in IDLE, then a clean frame
        clear_counts();
        bus.in_valid = 1'b1;
        bus.in_sof   = 1'b0;
        bus.win_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        drain(1);
        check("s3_sync_err", n_serr, 3);
        check("s3_shifts",   n_shift, 0);
        clear_counts();
        send_pixels(48, 1'b1, 0);
        drain(3);
        check("s3_windows",    n_win, 24);
        check("s3_frame_done", n_fd, 1);
        check("s3_sync_clean", n_serr, 0);

        // 4: in_sof arriving at (3,2) restarts the frame
        clear_counts();
        send_pixels(19, 1'b1, 0);
        bus.in_valid = 1'b1;
        bus.in_sof   = 1'b1;
        tick();
        check("s4_restart_col_row", int'({col, row}), 0);
        check("s4_sync_pulse",      int'(sync_err), 1);
        send_pixels(47, 1'b0, 0);
        drain(3);
        check("s4_windows",    n_win, 25);
        check("s4_sync_err",   n_serr, 1);
        check("s4_frame_done", n_fd, 1);
        check("s4_fd_acc",     fd_acc, 67);

        // 5: reset mid-row with a window held under backpressure
        clear_counts();
        send_pixels(19, 1'b1, 0);
        bus.win_ready = 1'b0;
        bus.in_valid  = 1'b1;
        tick();
        check("s5_held_valid", int'(bus.win_valid), 1);
        check("s5_backpress",  int'(bus.in_ready), 0);
        check("s5_no_shift",   int'(shift_en), 0);
        rst = 1'b1;
        #1;
        check("s5_rst_valid",    int'(bus.win_valid), 0);
        check("s5_rst_sof_eol",  int'({bus.win_sof, bus.win_eol}), 0);
        check("s5_rst_in_ready", int'(bus.in_ready), 1);
        check("s5_rst_shift",    int'(shift_en), 0);
        check("s5_rst_col_row",  int'({col, row}), 0);
        check("s5_rst_pulses",   int'({frame_done, sync_err}), 0);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_counts();
        send_pixels(48, 1'b1, 0);
        drain(3);
        check("s5_first_win_acc", first_win_acc, 19);
        check("s5_windows",       n_win, 24);
        check("s5_frame_done",    n_fd, 1);

        // 6: back-to-back frames
        clear_counts();
        send_pixels(48, 1'b1, 0);
        send_pixels(48, 1'b1, 0);
        drain(3);
        check("s6_fd_with_shift", n_fd_shift, 1);
        check("s6_frame_done",    n_fd, 2);
        check("s6_windows",       n_win, 48);
        check("s6_eol",           n_eol, 8);
        check("s6_win_sof",       n_wsof, 2);
        check("s6_sync_err",      n_serr, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
